// File: rtl/team_gpio_pkg.sv
// Shared register map, window size and encodings for the Wishbone GPIO bank.
package team_gpio_pkg;

    localparam logic [5:0]  OFF_OUT        = 6'h00;
    localparam logic [5:0]  OFF_OEB        = 6'h08;
    localparam logic [5:0]  OFF_IN         = 6'h10;
    localparam logic [5:0]  OFF_IRQ_MASK   = 6'h18;
    localparam logic [5:0]  OFF_IRQ_STATUS = 6'h20;
    localparam logic [5:0]  OFF_IRQ_POL    = 6'h28;
    localparam logic [5:0]  OFF_HI_WORD    = 6'h04;
    localparam logic [31:0] WINDOW_SIZE    = 32'h40;

    typedef enum logic {
        POL_RISING  = 1'b0,
        POL_FALLING = 1'b1
    } irq_pol_e;

    typedef enum logic [2:0] {
        REG_OUT,
        REG_OEB,
        REG_IN,
        REG_IRQ_MASK,
        REG_IRQ_STATUS,
        REG_IRQ_POL,
        REG_NONE
    } reg_sel_e;

    // Each register occupies an 8-byte LO/HI pair, so bits [5:3] pick the register.
    function automatic reg_sel_e decode_reg(input logic [5:0] off);
        logic [5:0] base;
        base = {off[5:3], 3'b000};
        case (base)
            OFF_OUT:        return REG_OUT;
            OFF_OEB:        return REG_OEB;
            OFF_IN:         return REG_IN;
            OFF_IRQ_MASK:   return REG_IRQ_MASK;
            OFF_IRQ_STATUS: return REG_IRQ_STATUS;
            OFF_IRQ_POL:    return REG_IRQ_POL;
            default:        return REG_NONE;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                                input logic [63:0] new_v,
                                                input logic [63:0] bmask);
        return (old_v & ~bmask) | (new_v & bmask);
    endfunction

endpackage

// File: rtl/team_gpio_sync.sv
// Multi-stage flop synchroniser for asynchronous pad inputs, cleared by reset.
module team_gpio_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             nrst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk_i or negedge nrst) begin
        if (!nrst) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/team_gpio_wb_bank.sv
// Wishbone-mapped GPIO bank with per-pin output enables and edge interrupts.
// Interrupt logic (mask/status/polarity/irq_o) is built only when GPIO_IRQ_EN is defined.
module team_gpio_wb_bank
    import team_gpio_pkg::*;
#(
    parameter int unsigned NUM_GPIO      = 38,
    parameter logic [63:0] RESERVED_MASK = 64'h1E,
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                clk_i,
    input  logic                nrst,
    input  logic                cyc_i,
    input  logic                stb_i,
    input  logic                we_i,
    input  logic [3:0]          sel_i,
    input  logic [31:0]         adr_i,
    input  logic [31:0]         dat_i,
    output logic                ack_o,
    output logic [31:0]         dat_o,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] gpio_out,
    output logic [NUM_GPIO-1:0] gpio_oeb,
    output logic                irq_o
);

    localparam logic [63:0] VALID_MASK = (NUM_GPIO >= 64) ? '1 : ((64'd1 << NUM_GPIO) - 64'd1);

    logic                ack_q;
    logic [31:0]         dat_q, dat_d;
    logic [63:0]         out_q, out_d;
    logic [63:0]         oeb_q, oeb_d;
    logic [NUM_GPIO-1:0] gpio_out_q, gpio_oeb_q;
    logic [NUM_GPIO-1:0] sync_w;
    logic [63:0]         in_w, mask_w, status_w, pol_w;
    logic [31:0]         offs_w;
    logic [5:0]          off_w;
    logic                in_win, acc, wr, word_hi;
    reg_sel_e            sel_reg;
    logic [63:0]         wmask, wdata, rd64;

    // Subtracting the base handles the window check and the offset in one step.
    assign offs_w  = adr_i - BASE_ADDR;
    assign in_win  = offs_w < WINDOW_SIZE;
    assign off_w   = offs_w[5:0];
    assign acc     = cyc_i & stb_i & ~ack_q & in_win;
    assign wr      = acc & we_i;
    assign word_hi = (off_w & OFF_HI_WORD) != 6'h00;
    assign sel_reg = decode_reg(off_w);
    assign wmask   = (word_hi ? {lane_mask(sel_i), 32'h0} : {32'h0, lane_mask(sel_i)}) & VALID_MASK;
    assign wdata   = {dat_i, dat_i};

    team_gpio_sync #(
        .WIDTH  (NUM_GPIO),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_i),
        .nrst  (nrst),
        .d_i   (gpio_in),
        .q_o   (sync_w)
    );

    always_comb begin
        in_w = '0;
        in_w[NUM_GPIO-1:0] = sync_w;
    end

    always_comb begin
        out_d = out_q;
        oeb_d = oeb_q;
        if (wr && sel_reg == REG_OUT) out_d = merge_bytes(out_q, wdata, wmask);
        if (wr && sel_reg == REG_OEB) oeb_d = merge_bytes(oeb_q, wdata, wmask);
    end

    always_comb begin
        case (sel_reg)
            REG_OUT:        rd64 = out_q;
            REG_OEB:        rd64 = oeb_q;
            REG_IN:         rd64 = in_w;
            REG_IRQ_MASK:   rd64 = mask_w;
            REG_IRQ_STATUS: rd64 = status_w;
            REG_IRQ_POL:    rd64 = pol_w;
            default:        rd64 = '0;
        endcase
        dat_d = word_hi ? rd64[63:32] : rd64[31:0];
    end

    always_ff @(posedge clk_i or negedge nrst) begin
        if (!nrst) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            out_q      <= '0;
            oeb_q      <= VALID_MASK;
            gpio_out_q <= '0;
            gpio_oeb_q <= '1;
        end else begin
            ack_q      <= acc;
            if (acc) dat_q <= dat_d;
            out_q      <= out_d;
            oeb_q      <= oeb_d;
            gpio_out_q <= out_q[NUM_GPIO-1:0] & ~RESERVED_MASK[NUM_GPIO-1:0];
            gpio_oeb_q <= oeb_q[NUM_GPIO-1:0] | RESERVED_MASK[NUM_GPIO-1:0];
        end
    end

    assign ack_o    = ack_q;
    assign dat_o    = dat_q;
    assign gpio_out = gpio_out_q;
    assign gpio_oeb = gpio_oeb_q;

`ifdef GPIO_IRQ_EN
    localparam logic [63:0] IRQ_PINS = VALID_MASK & ~RESERVED_MASK;

    logic [63:0] mask_q, mask_d;
    logic [63:0] status_q, status_d;
    logic [63:0] pol_q, pol_d;
    logic [63:0] prev_q, edge_w;
    logic [2:0]  settle_q;
    logic        armed, irq_q;

    // Edges stay disarmed until prev_q holds a value that has crossed the whole synchroniser.
    assign armed = settle_q > 3'(SYNC_STAGES);

    always_comb begin
        edge_w = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (irq_pol_e'(pol_q[i]) == POL_FALLING) edge_w[i] = prev_q[i] & ~in_w[i];
            else                                      edge_w[i] = in_w[i] & ~prev_q[i];
        end
        edge_w = armed ? (edge_w & IRQ_PINS) : '0;

        mask_d   = mask_q;
        pol_d    = pol_q;
        status_d = status_q;
        if (wr && sel_reg == REG_IRQ_MASK)   mask_d   = merge_bytes(mask_q, wdata, wmask);
        if (wr && sel_reg == REG_IRQ_POL)    pol_d    = merge_bytes(pol_q, wdata, wmask);
        if (wr && sel_reg == REG_IRQ_STATUS) status_d = status_q & ~(wdata & wmask);
        status_d = status_d | edge_w;
    end

    always_ff @(posedge clk_i or negedge nrst) begin
        if (!nrst) begin
            mask_q   <= '0;
            status_q <= '0;
            pol_q    <= '0;
            prev_q   <= '0;
            settle_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            mask_q   <= mask_d;
            status_q <= status_d;
            pol_q    <= pol_d;
            prev_q   <= in_w;
            settle_q <= armed ? settle_q : settle_q + 3'd1;
            irq_q    <= |(status_q & mask_q);
        end
    end

    assign mask_w   = mask_q;
    assign status_w = status_q;
    assign pol_w    = pol_q;
    assign irq_o    = irq_q;
`else
    assign mask_w   = '0;
    assign status_w = '0;
    assign pol_w    = '0;
    assign irq_o    = 1'b0;
`endif

endmodule

// File: doc/team_gpio_wb_bank.md
TEAM_GPIO_WB_BANK -- requirements
Module: team_gpio_wb_bank

Interface
REQ-001 SHALL have parameter NUM_GPIO, default 38: GPIO channel count, legal range 1..64.
REQ-002 SHALL have parameter RESERVED_MASK, default 64'h1E: pins forced to input and excluded from IRQ (GPIO 4:1).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h3000_0000: 64-byte-aligned register window base.
REQ-004 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 2..3.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, named as follows:
- clk_i  in  1  sole clock, all logic rising-edge.
- nrst  in  1  asynchronous active-low reset.
REQ-006 SHALL have these Wishbone ports:
- cyc_i  in  1  bus cycle.
- stb_i  in  1  strobe.
- we_i  in  1  write enable.
- sel_i  in  4  byte lane selects.
- adr_i  in  32  byte address.
- dat_i  in  32  write data.
- ack_o  out  1  acknowledge.
- dat_o  out  32  read data.
REQ-007 SHALL have these GPIO and interrupt ports:
- gpio_in  in  NUM_GPIO  raw pad inputs.
- gpio_out  out  NUM_GPIO  pad output values.
- gpio_oeb  out  NUM_GPIO  active-low output enables.
- irq_o  out  1  level interrupt.

Function
REQ-008 SHALL decode adr_i[5:0] within BASE_ADDR..BASE_ADDR+0x3F; each register is split into a LO word (bits 31:0) and a HI word (bits 63:32); register map:
- OUT 0x00/0x04.
- OEB 0x08/0x0C.
- IN 0x10/0x14 (RO).
- IRQ_MASK 0x18/0x1C.
- IRQ_STATUS 0x20/0x24 (W1C).
- IRQ_POL 0x28/0x2C (0=rising, 1=falling).
REQ-009 SHALL assert ack_o for exactly one cycle, one cycle after cyc_i&stb_i with an in-window address; it SHALL deassert ack_o in the next cycle even if stb_i stays high, so a held strobe acks every other cycle.
REQ-010 SHALL ignore out-of-window addresses: no ack, no state change, dat_o holds its value.
REQ-011 SHALL ack in-window unmapped offsets (0x30-0x3F) with dat_o=0 and no state change.
REQ-012 SHALL apply writes per byte lane under sel_i, and only on the cycle ack_o is driven high.
REQ-013 SHALL register read data into dat_o on the ack cycle; bits at or above NUM_GPIO SHALL read 0 and ignore writes.
REQ-014 SHALL drive gpio_out=OUT & ~RESERVED_MASK and gpio_oeb=OEB | RESERVED_MASK, both registered, with 1-cycle latency from the write ack.
REQ-015 SHALL read IN as gpio_in passed through SYNC_STAGES flops; total latency from pad to readable is SYNC_STAGES cycles.
REQ-016 SHALL set IRQ_STATUS[i] on an edge of synchronised input i whose direction matches IRQ_POL[i], for non-reserved i only.
REQ-017 SHALL clear an IRQ_STATUS bit on a write of 1 to that bit; writes of 0 SHALL have no effect.
REQ-018 SHALL let set win when an edge and a W1C clear hit the same bit in the same cycle.
REQ-019 SHALL drive irq_o as a register of |(IRQ_STATUS & IRQ_MASK), 1 cycle after the status/mask change.
REQ-020 SHALL not change IRQ_STATUS when IRQ_MASK changes; masking only gates irq_o.

Reset
REQ-021 SHALL set on nrst low, asynchronously:
- OUT=0, IRQ_MASK=0, IRQ_STATUS=0, IRQ_POL=0, synchroniser flops=0.
- OEB=all ones.
- ack_o=0, dat_o=0, irq_o=0.
- gpio_out=0, gpio_oeb=all ones.
REQ-022 SHALL abandon any in-flight transaction on nrst low, with no ack after release.
REQ-023 SHALL not detect a spurious edge in the first SYNC_STAGES cycles after reset release.

Configuration
REQ-024 SHALL, when GPIO_IRQ_EN is defined, implement IRQ_MASK, IRQ_STATUS, IRQ_POL, edge detection and irq_o as specified.
REQ-025 SHALL, when GPIO_IRQ_EN is undefined, omit that logic: IRQ offsets read 0 with ack and ignore writes, and irq_o is tied to 0.

Structure
REQ-026 SHALL take register offsets, the window size (0x40) and the IRQ_POL encoding enum from shared package team_gpio_pkg.
REQ-027 SHALL implement the synchroniser as sub-module team_gpio_sync, parameterised by width and stage count.

Verification
REQ-028 SHALL cover: write OUT_LO=0xFFFF_FFFF, sel_i=4'hF, OEB_LO=0 -> gpio_out[31:0]=0xFFFF_FFE1 and gpio_oeb[4:1]=4'hF.
REQ-029 SHALL cover: write OUT_LO=0x1234_5678 with sel_i=4'b0010 over a zero register -> OUT_LO reads 0x0000_5600.
REQ-030 SHALL cover: IRQ_MASK_LO=0x20, IRQ_POL=0, gpio_in[5] rises -> IRQ_STATUS_LO=0x20 and irq_o=1 by cycle SYNC_STAGES+2; W1C 0x20 -> irq_o=0.
REQ-031 SHALL cover: W1C of bit 5 coincident with a new rising edge on pin 5 -> bit stays 1.
REQ-032 SHALL cover: read at BASE_ADDR+0x40 -> no ack within 4 cycles; read at 0x34 -> ack with dat_o=0.
REQ-033 SHALL cover: nrst pulsed low while stb_i is high -> ack_o=0, gpio_oeb all ones, and irq_o=0 immediately.
